// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - sequencer driving an external up/down counter through a programmable triangle sweep
module sweep_ctrl #(
    parameter int WIDTH = 8,
    parameter int SW    = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [SW-1:0]    nsweeps_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             cnt_rst_o,
    output logic             cnt_en_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cfg_err_o,
    output logic [SW-1:0]    sweep_cnt_o
);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [SW-1:0]    nsweeps_q;
    logic [SW-1:0]    sweep_cnt_q, sweep_cnt_d;
    logic [SW-1:0]    sweep_inc;
    logic             accept_d;
    logic             cfg_err_d;
    logic             cnt_rst_q, cnt_en_q, busy_q, done_q, cfg_err_q;

    assign sweep_inc = sweep_cnt_q + SW'(1);

    // Turn points are one step early: the counter lands on hi/lo on the same edge.
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        accept_d    = 1'b0;
        cfg_err_d   = 1'b0;
        case (state_q)
            S_CLEAR: state_d = S_IDLE;
            S_IDLE: begin
                if (start_i) begin
                    if ((hi_i > lo_i) && (nsweeps_i != '0)) begin
                        accept_d    = 1'b1;
                        sweep_cnt_d = '0;
                        state_d     = S_UP;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_UP: begin
                if (abort_i) begin
                    state_d = S_CLEAR;
                end else if (count_i == hi_q - WIDTH'(1)) begin
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                if (abort_i) begin
                    state_d = S_CLEAR;
                end else if (count_i == lo_q + WIDTH'(1)) begin
                    sweep_cnt_d = sweep_inc;
                    state_d     = (sweep_inc == nsweeps_q) ? S_DONE : S_UP;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_CLEAR;
            hi_q        <= '0;
            lo_q        <= '0;
            nsweeps_q   <= '0;
            sweep_cnt_q <= '0;
            cnt_rst_q   <= 1'b1;
            cnt_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            cfg_err_q   <= cfg_err_d;
            if (accept_d) begin
                hi_q      <= hi_i;
                lo_q      <= lo_i;
                nsweeps_q <= nsweeps_i;
            end
            // Outputs are decoded from the next state so they line up with state_q.
            cnt_rst_q <= (state_d == S_CLEAR) || (state_d == S_IDLE) || (state_d == S_DONE);
            cnt_en_q  <= (state_d == S_UP);
            busy_q    <= (state_d == S_UP) || (state_d == S_DOWN);
            done_q    <= (state_d == S_DONE);
        end
    end

    assign cnt_rst_o   = cnt_rst_q;
    assign cnt_en_o    = cnt_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign cfg_err_o   = cfg_err_q;
    assign sweep_cnt_o = sweep_cnt_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - self-checking bench for sweep_ctrl with an attached counter model
module tb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, abort;
    logic [7:0] hi, lo;
    logic [3:0] nsweeps;
    logic [7:0] cnt;
    logic       cnt_rst, cnt_en, busy, done, cfg_err;
    logic [3:0] sweep_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sweep_ctrl #(.WIDTH(8), .SW(4)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .hi_i        (hi),
        .lo_i        (lo),
        .nsweeps_i   (nsweeps),
        .count_i     (cnt),
        .cnt_rst_o   (cnt_rst),
        .cnt_en_o    (cnt_en),
        .busy_o      (busy),
        .done_o      (done),
        .cfg_err_o   (cfg_err),
        .sweep_cnt_o (sweep_cnt)
    );

    // External counter: sync active-high reset, counts up when en=1, down otherwise.
    always @(posedge clk) begin
        if (cnt_rst)     cnt <= 8'd0;
        else if (cnt_en) cnt <= cnt + 8'd1;
        else             cnt <= cnt - 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_parked(input string tag, input int exp_sweeps);
        chk({tag, ".cnt_rst"}, cnt_rst, 1);
        chk({tag, ".cnt_en"}, cnt_en, 0);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".sweep_cnt"}, sweep_cnt, exp_sweeps);
    endtask

    // Walks a run that entered UP at the previous edge, against the arithmetic sweep shape.
    task automatic follow(input int h, input int l, input int n, input int abort_idx);
        int  q[$];
        bit  up[$];
        int  sw[$];
        for (int c = 0; c < h; c++) begin q.push_back(c); up.push_back(1); sw.push_back(0); end
        for (int s = 1; s <= n; s++) begin
            for (int c = h; c > l; c--) begin q.push_back(c); up.push_back(0); sw.push_back(s - 1); end
            if (s < n)
                for (int c = l; c < h; c++) begin q.push_back(c); up.push_back(1); sw.push_back(s); end
        end
        for (int k = 0; k < q.size(); k++) begin
            chk("run.count", cnt, q[k]);
            chk("run.cnt_en", cnt_en, up[k]);
            chk("run.busy", busy, 1);
            chk("run.cnt_rst", cnt_rst, 0);
            chk("run.done", done, 0);
            chk("run.sweep_cnt", sweep_cnt, sw[k]);
            if (k == abort_idx) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                chk_parked("abort", sw[k]);
                chk("abort.done", done, 0);
                chk("abort.count", cnt, up[k] ? q[k] + 1 : q[k] - 1);
                step();
                chk("abort.count0", cnt, 0);
                chk_parked("abort.idle", sw[k]);
                chk("abort.done2", done, 0);
                return;
            end
            step();
        end
        chk("done.pulse", done, 1);
        chk("done.count", cnt, l);
        chk_parked("done", n);
        step();
        chk("idle.done", done, 0);
        chk("idle.count", cnt, 0);
        chk_parked("idle", n);
    endtask

    task automatic start_run(input int h, input int l, input int n, input int abort_idx);
        hi = 8'(h); lo = 8'(l); nsweeps = 4'(n); start = 1'b1;
        step();
        start = 1'b0;
        hi = 8'($urandom); lo = 8'($urandom); nsweeps = 4'($urandom);
        follow(h, l, n, abort_idx);
    endtask

    task automatic bad_start(input int h, input int l, input int n);
        hi = 8'(h); lo = 8'(l); nsweeps = 4'(n); start = 1'b1;
        step();
        start = 1'b0;
        chk("bad.cfg_err", cfg_err, 1);
        chk_parked("bad", sweep_cnt);
        chk("bad.count", cnt, 0);
        step();
        chk("bad.cfg_err_clr", cfg_err, 0);
        chk("bad.busy", busy, 0);
    endtask

    // Release reset with start already high: the CLEAR cycle must ignore it, IDLE must take it.
    task automatic release_and_start(input int h, input int l, input int n);
        hi = 8'(h); lo = 8'(l); nsweeps = 4'(n); start = 1'b1;
        rst_n = 1'b1;
        step();
        chk("rel.busy_ignored", busy, 0);
        chk("rel.cnt_rst", cnt_rst, 1);
        step();
        start = 1'b0;
        chk("rel.busy_accepted", busy, 1);
        follow(h, l, n, -1);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        hi = 8'd0; lo = 8'd0; nsweeps = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_parked("reset", 0);
        chk("reset.done", done, 0);
        chk("reset.cfg_err", cfg_err, 0);
        chk("reset.count", cnt, 0);

        release_and_start(3, 1, 2);
        start_run(1, 0, 3, -1);
        bad_start(5, 5, 2);
        bad_start(4, 1, 0);
        bad_start(2, 7, 3);
        // Second sweep UP at count 7: 10 first-UP + 8 DOWN + (7-2).
        start_run(10, 2, 4, 23);

        hi = 8'd6; lo = 8'd2; nsweeps = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        repeat (7) step();
        chk("middown.count", cnt, 5);
        rst_n = 1'b0;
        #1;
        chk_parked("middown.rst", 0);
        @(posedge clk);
        #1;
        chk("middown.count0", cnt, 0);
        @(negedge clk);
        release_and_start(5, 3, 1);

        hi = 8'd4; lo = 8'd1; nsweeps = 4'd1; start = 1'b1;
        step();
        hi = 8'd3; lo = 8'd2; nsweeps = 4'd2;
        follow(4, 1, 1, -1);
        step();
        start = 1'b0;
        chk("b2b.sweep_clr", sweep_cnt, 0);
        follow(3, 2, 2, -1);

        for (int i = 0; i < 10; i++) begin
            int h, l, n, len, ab;
            h = $urandom_range(12, 1);
            l = $urandom_range(h - 1, 0);
            n = $urandom_range(4, 1);
            len = h + n * (h - l) + (n - 1) * (h - l);
            ab = ($urandom_range(2, 0) == 0) ? $urandom_range(len - 1, 0) : -1;
            if ($urandom_range(1, 0) == 1) bad_start(l, h, n);
            start_run(h, l, n, ab);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
